// File: rtl/mcp01_stack.sv
// -----------------------------------------------------------------------------
// mcp01_stack
//   Hardware operand stack for the multicycle stack-based processor. Responds to
//   the controller's push/pop/tos strobes. It holds a LIFO of WIDTH-bit words,
//   has a registered read port (one-cycle latency), full/empty/count status, and
//   sticky overflow/underflow error flags.
//
// Parameters
//   WIDTH  data word width
//   DEPTH  number of entries (power of two, >= 2)
//   AW     log2(DEPTH)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   push       write d_in onto the stack
//   pop        remove the top entry and register it onto d_out
//   tos        copy the top entry to d_out without removing it
//   d_in       data to push
//   clr_err    synchronous clear of overflow/underflow
//   d_out      registered read data; holds until the next successful pop/tos
//   d_zero     d_out == 0 (combinational from d_out)
//   empty      count == 0
//   full       count == DEPTH
//   count      number of valid entries
//   overflow   sticky: push attempted while full
//   underflow  sticky: pop or tos attempted while empty
// -----------------------------------------------------------------------------
module mcp01_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] d_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] d_out,
  output logic             d_zero,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  // Storage and state
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      sp_q, sp_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  // Write-port controls for the storage array
  logic             wr_en;
  logic [AW-1:0]    wr_addr;

  // Derived status
  logic             is_empty, is_full;
  logic [AW-1:0]    top_idx;
  logic             replace_top;
  logic             push_normal;
  logic             pop_only;
  logic             rd_en;
  logic             ovf_event, unf_event;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == (AW+1)'(DEPTH));

  // Index of the top entry. Arithmetic is done in AW bits so that a full stack
  // (sp == DEPTH, low bits all zero) wraps to DEPTH-1, which is the real top.
  assign top_idx = sp_q[AW-1:0] - AW'(1);

  // push+pop on a non-empty stack rewrites the top in place (legal even when full)
  assign replace_top = push && pop && !is_empty;
  // Ordinary push: anything else with push set, provided there is room. A
  // push+pop on an empty stack lands here since the pop half fails.
  assign push_normal = push && !replace_top && !is_full;
  assign pop_only    = pop && !push && !is_empty;

  // pop or tos both read the pre-update top; tos alongside pop is redundant.
  assign rd_en     = (pop || tos) && !is_empty;
  assign ovf_event = push && !pop && is_full;
  assign unf_event = (pop || tos) && is_empty;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    sp_d        = sp_q;
    d_out_d     = d_out_q;
    wr_en       = 1'b0;
    wr_addr     = sp_q[AW-1:0];
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (replace_top) begin
      wr_en   = 1'b1;
      wr_addr = top_idx;
    end else if (push_normal) begin
      wr_en   = 1'b1;
      wr_addr = sp_q[AW-1:0];
      sp_d    = sp_q + 1'b1;
    end else if (pop_only) begin
      sp_d    = sp_q - 1'b1;
    end

    if (rd_en) begin
      d_out_d = mem[top_idx];
    end

    // Clear first, then let a same-cycle error event re-set the flag.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ovf_event) overflow_d  = 1'b1;
    if (unf_event) underflow_d = 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q        <= '0;
      d_out_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      d_out_q     <= d_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; entries above sp are never read, so
  // clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= d_in;
    end
  end

  assign d_out     = d_out_q;
  assign d_zero    = (d_out_q == '0);
  assign empty     = is_empty;
  assign full      = is_full;
  assign count     = sp_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/mcp01_stack.md
Name: mcp01_stack

Overview:
- Hardware operand stack for the multicycle stack-based processor: the responder to the controller's push/pop/tos strobes.
- Holds a LIFO of data words with a registered read port and full/empty status.
- Reports sticky overflow/underflow errors.
- Supplies operands to the ALU operand registers and to the memory write path, and supplies the top-of-stack value plus a zero flag to the jump-if-zero logic.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries; must be a power of two and at least 2.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  write d_in onto the stack this cycle.
- pop  input  1  remove the top entry and register it onto d_out.
- tos  input  1  copy the top entry to d_out without removing it.
- d_in  input  WIDTH  data to push (already muxed by the datapath).
- clr_err  input  1  synchronous clear of the sticky error flags.
- d_out  output  WIDTH  registered read data.
- d_zero  output  1  high when d_out == 0; combinational from d_out.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  AW+1  number of valid entries.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop or tos was attempted while empty.

Behaviour:
- Storage: DEPTH x WIDTH register array, not reset. sp (AW+1 bits) is the count; the top entry is mem[sp-1].
- Async reset: sp=0, d_out=0, overflow=0, underflow=0. Consequently empty=1, full=0, count=0, d_zero=1. A reset mid-sequence discards all entries immediately.
- All other state updates on the rising edge of clk.
- Read latency is 1 cycle: d_out is valid the cycle after a pop or tos (the pop state is followed by the operand-load state). d_out holds its value until the next successful pop or tos.
- Push only, not full: mem[sp] <= d_in, sp <= sp+1; d_out unchanged.
- Pop only, not empty: d_out <= mem[sp-1], sp <= sp-1.
- Tos (with no push or pop), not empty: d_out <= mem[sp-1]; sp unchanged.
- Push and pop together, not empty (replace top): d_out <= mem[sp-1] (old top), mem[sp-1] <= d_in, sp unchanged.
- Push and pop together, empty: the pop fails, underflow <= 1. The push proceeds normally: mem[0] <= d_in, sp <= 1. d_out unchanged.
- tos asserted together with pop: tos is ignored; the pop result governs d_out.
- tos asserted together with push only: d_out <= old top (pre-push); the push proceeds normally. If empty, underflow <= 1 and the push still proceeds.
- Push when full (without pop): memory and sp unchanged, overflow <= 1.
- Pop or tos when empty: sp and d_out unchanged, underflow <= 1.
- Full boundary: push and pop together while full is a legal replace-top; no overflow.
- No wrap-around: sp saturates at 0 and DEPTH; the pointer never wraps.
- clr_err=1: overflow <= 0 and underflow <= 0. A new error event in the same cycle wins; the flag is set.
- Status outputs (empty, full, count) are derived from sp. They reflect the new sp in the cycle after the update edge.

Test Plan:
- Reset then push 0x11, 0x22, 0x33 on consecutive cycles -> count=3. Pop, then one cycle later d_out=0x33; pop, then d_out=0x22; count=1; no flags set.
- Operand flow: push 0x05, push 0x03; pop -> d_out=0x03; pop -> d_out=0x05; empty=1. Pop again -> underflow=1, d_out stays 0x05, count stays 0.
- Fill with DEPTH pushes of values 0..15 -> full=1. 17th push of 0xAA -> overflow=1, count=16. Pop -> d_out=0x0F (not 0xAA). Assert clr_err -> both flags 0.
- Tos/zero: push 0x00, assert tos -> d_out=0x00, d_zero=1, count unchanged at 1. Push 0x07, tos -> d_out=0x07, d_zero=0.
- Simultaneous: stack holds [0x01, 0x02 (top)]; push+pop with d_in=0x09 -> d_out=0x02, count=2. Pop -> d_out=0x09.
- Async reset mid-stream: with count=5, assert rst between clock edges -> empty=1, count=0, d_out=0, flags 0 immediately, before the next edge. After release, the first push lands in entry 0.
